sdram_port_arbiter: RTL and testbench

//  N-port successor to the fixed CPU-instr/CPU-data/VGA memory map. Arbitrates NUM_PORTS requesters onto one sdram_ctl.

---
 rtl/sdram_port_arbiter_if.sv | 40 ++++
 rtl/sdram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Requester-side and sdram_ctl-side signal bundle for the N-port SDRAM arbiter.
interface sdram_port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 32
);
    logic [NUM_PORTS-1:0]          req;
    logic [NUM_PORTS-1:0]          req_we;
    logic [NUM_PORTS-1:0]          req_burst;
    logic [NUM_PORTS*ADDR_W-1:0]   req_addr;
    logic [NUM_PORTS*DATA_W-1:0]   req_wdata;
    logic [NUM_PORTS-1:0]          done;
    logic [DATA_W-1:0]             rdata;
    logic [BURST_LEN*DATA_W-1:0]   burst_rdata;
    logic                          busy;
    logic                          dram_mem_ready;
    logic                          dram_data_ready;
    logic [DATA_W-1:0]             dram_read_data;
    logic [BURST_LEN*DATA_W-1:0]   dram_burst_buf;
    logic                          dram_refresh_data;
    logic                          dram_write_en;
    logic                          dram_burst_en;
    logic [ADDR_W-1:0]             dram_addr;
    logic [DATA_W-1:0]             dram_data_in;

    modport slave (
        input  req, req_we, req_burst, req_addr, req_wdata,
        input  dram_mem_ready, dram_data_ready, dram_read_data, dram_burst_buf,
        output done, rdata, burst_rdata, busy,
        output dram_refresh_data, dram_write_en, dram_burst_en, dram_addr, dram_data_in
    );

    modport master (
        output req, req_we, req_burst, req_addr, req_wdata,
        output dram_mem_ready, dram_data_ready, dram_read_data, dram_burst_buf,
        input  done, rdata, burst_rdata, busy,
        input  dram_refresh_data, dram_write_en, dram_burst_en, dram_addr, dram_data_in
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Arbitrates NUM_PORTS single-word/burst requesters onto one sdram_ctl, one transaction at a time.
// Round-robin or fixed-priority grant; all outputs are registered.
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_port_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W:0] NUM_PORTS_W = (IDX_W+1)'(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      state_r;
    state_t                      state_next_s;
    logic                        grant_valid_s;
    logic [IDX_W-1:0]            grant_idx_s;
    logic [IDX_W:0]              cand_s;
    logic [IDX_W-1:0]            rr_ptr_r;
    logic [IDX_W-1:0]            idx_r;
    logic                        we_r;
    logic                        burst_r;
    logic [ADDR_W-1:0]           addr_r;
    logic [DATA_W-1:0]           wdata_r;
    logic [DATA_W-1:0]           rdata_r;
    logic [BURST_LEN*DATA_W-1:0] burst_rdata_r;
    logic [NUM_PORTS-1:0]        done_r;
    logic                        busy_r;
    logic                        strobe_r;

    // Winner search: from rr_ptr (round-robin) or from port 0 (fixed priority)
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {IDX_W{1'b0}};
        cand_s        = {(IDX_W+1){1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (PRIO_MODE == 1) begin
                cand_s = (IDX_W+1)'(k);
            end else begin
                cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
                if (cand_s >= NUM_PORTS_W) begin
                    cand_s = cand_s - NUM_PORTS_W;
                end else begin
                end
            end
            if (!grant_valid_s && bus.req[cand_s[IDX_W-1:0]]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = cand_s[IDX_W-1:0];
            end else begin
            end
        end
    end

    // Next-state logic; dram_data_ready only counts while waiting
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_valid_s && bus.dram_mem_ready) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: state_next_s = WAIT;
            WAIT: begin
                if (bus.dram_data_ready) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the winning command and advance the round-robin pointer on grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r    <= {IDX_W{1'b0}};
            we_r     <= 1'b0;
            burst_r  <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if (state_r == IDLE && state_next_s == ISSUE) begin
            idx_r    <= grant_idx_s;
            we_r     <= bus.req_we[grant_idx_s] & ~bus.req_burst[grant_idx_s];
            burst_r  <= bus.req_burst[grant_idx_s];
            addr_r   <= bus.req_addr[grant_idx_s*ADDR_W +: ADDR_W];
            wdata_r  <= bus.req_wdata[grant_idx_s*DATA_W +: DATA_W];
            rr_ptr_r <= (grant_idx_s == LAST_PORT) ? {IDX_W{1'b0}} : grant_idx_s + IDX_W'(1);
        end else begin
            idx_r    <= idx_r;
        end
    end

    // Capture read data on completion; a burst reports its first word on rdata
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r       <= {DATA_W{1'b0}};
            burst_rdata_r <= {(BURST_LEN*DATA_W){1'b0}};
        end else if (state_r == WAIT && bus.dram_data_ready) begin
            rdata_r       <= burst_r ? bus.dram_burst_buf[DATA_W-1:0] : bus.dram_read_data;
            burst_rdata_r <= bus.dram_burst_buf;
        end else begin
            rdata_r       <= rdata_r;
        end
    end

    // Registered strobe, completion pulse and busy flag, derived from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strobe_r <= 1'b0;
            done_r   <= {NUM_PORTS{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            strobe_r <= (state_next_s == ISSUE);
            done_r   <= (state_next_s == DONE) ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << idx_r)
                                               : {NUM_PORTS{1'b0}};
            busy_r   <= (state_next_s != IDLE);
        end
    end

    assign bus.dram_refresh_data = strobe_r;
    assign bus.dram_write_en     = we_r;
    assign bus.dram_burst_en     = burst_r;
    assign bus.dram_addr         = addr_r;
    assign bus.dram_data_in      = wdata_r;
    assign bus.done              = done_r;
    assign bus.rdata             = rdata_r;
    assign bus.burst_rdata       = burst_rdata_r;
    assign bus.busy              = busy_r;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a timestamp-based transaction model.
module tb_sdram_port_arbiter;
    localparam int NP = 4;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BL = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sdram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) bus ();
    sdram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) bus_p ();

    sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .PRIO_MODE(0))
        dut (.clk(clk), .rst(rst), .bus(bus));
    sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .PRIO_MODE(1))
        dut_p (.clk(clk), .rst(rst), .bus(bus_p));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [DW-1:0] sd_mem  [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] sd_rd(input logic [AW-1:0] a);
        return sd_mem.exists(a) ? sd_mem[a] : 16'h0000;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference arbitration rule
    function automatic int pick(input logic [NP-1:0] r, input int ptr, input int prio);
        for (int k = 0; k < NP; k++) begin
            int c;
            c = (prio != 0) ? k : (ptr + k) % NP;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // ---------------- transaction model + per-cycle compare ----------------
    int            cyc;
    bit            m_busy;
    int            m_g, m_done_cyc, m_free_from, m_rr, m_idx;
    logic          m_we, m_burst;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_exp_rd;
    logic [BL*DW-1:0] m_exp_burst;

    initial begin : compare
        int w;
        cyc = 0; m_busy = 0; m_g = 0; m_done_cyc = -1; m_free_from = 0; m_rr = 0; m_idx = 0;
        m_we = 0; m_burst = 0; m_addr = '0; m_wdata = '0; m_exp_rd = '0; m_exp_burst = '0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst) begin
                if (m_busy && m_done_cyc >= 0 && cyc == m_done_cyc + 1) begin
                    m_busy = 0;
                    m_free_from = cyc + 1;
                end
                if (!m_busy && cyc >= m_free_from && bus.req != 4'h0 && bus.dram_mem_ready) begin
                    w = pick(bus.req, m_rr, 0);
                    m_idx = w;
                    m_we = bus.req_we[w] & ~bus.req_burst[w];
                    m_burst = bus.req_burst[w];
                    m_addr = bus.req_addr[w*AW +: AW];
                    m_wdata = bus.req_wdata[w*DW +: DW];
                    m_rr = (w + 1) % NP;
                    m_busy = 1; m_g = cyc; m_done_cyc = -1;
                end else if (m_busy && m_done_cyc < 0 && cyc >= m_g + 2 && bus.dram_data_ready) begin
                    m_done_cyc = cyc;
                    if (m_we) ref_mem[m_addr] = m_wdata;
                    m_exp_rd = ref_rd(m_addr);
                    for (int k = 0; k < BL; k++) m_exp_burst[k*DW +: DW] = ref_rd(m_addr + AW'(k));
                end
            end
            @(negedge clk);
            if (!rst) begin
                m_busy = 0; m_rr = 0; m_free_from = 0; m_done_cyc = -1;
                chk("rst_done", bus.done, 4'h0);
                chk("rst_busy", bus.busy, 1'b0);
                chk("rst_strobe", bus.dram_refresh_data, 1'b0);
                chk("rst_rdata", bus.rdata, 16'h0000);
                chk("rst_burst_rdata", bus.burst_rdata, 512'h0);
                chk("rst_cmd", {bus.dram_write_en, bus.dram_burst_en, bus.dram_addr, bus.dram_data_in}, 43'h0);
            end else begin
                chk("done", bus.done, (m_busy && cyc == m_done_cyc) ? (4'b0001 << m_idx) : 4'h0);
                chk("busy", bus.busy, m_busy);
                chk("strobe", bus.dram_refresh_data, (m_busy && cyc == m_g));
                if (m_busy && cyc == m_g) begin
                    chk("cmd_addr", bus.dram_addr, m_addr);
                    chk("cmd_we", bus.dram_write_en, m_we);
                    chk("cmd_burst", bus.dram_burst_en, m_burst);
                    if (m_we) chk("cmd_wdata", bus.dram_data_in, m_wdata);
                end
                if (m_busy && cyc == m_done_cyc && !m_we) begin
                    chk("rdata", bus.rdata, m_exp_rd);
                    if (m_burst) chk("burst_rdata", bus.burst_rdata, m_exp_burst);
                end
            end
        end
    end

    // ---------------- stimulus: requesters + sdram_ctl model ----------------
    logic [NP-1:0] hold_all;
    bit            rand_en;
    int            force_delay, sd_cnt, p_cnt, strobe_cnt;
    logic [AW-1:0] sd_addr, last_saddr;
    logic          sd_we, sd_burst, last_sburst, last_swe;
    logic [DW-1:0] sd_wdata;
    logic [NP-1:0] done_log [$];
    logic [NP-1:0] pdone_log [$];
    logic [DW-1:0] rd_log [$];
    logic [BL*DW-1:0] bst_log [$];

    task automatic set_port(input int i, input logic we, input logic burst, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        bus.req_we[i] = we;
        bus.req_burst[i] = burst;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
        bus.req[i] = 1'b1;
    endtask

    task automatic sdram_step();
        if (!rst) begin
            sd_cnt = 0;
            bus.dram_data_ready = 1'b0;
        end else begin
            bus.dram_data_ready = 1'b0;
            if (bus.dram_refresh_data) begin
                sd_addr = bus.dram_addr; sd_we = bus.dram_write_en;
                sd_burst = bus.dram_burst_en; sd_wdata = bus.dram_data_in;
                sd_cnt = (force_delay > 0) ? force_delay : $urandom_range(1, 4);
                if ($urandom_range(0, 3) == 0) begin
                    bus.dram_data_ready = 1'b1;
                    bus.dram_read_data = 16'($urandom);
                end
            end else if (sd_cnt > 0) begin
                sd_cnt--;
                if (sd_cnt == 0) begin
                    bus.dram_data_ready = 1'b1;
                    if (sd_we) sd_mem[sd_addr] = sd_wdata;
                    bus.dram_read_data = sd_burst ? 16'($urandom) : sd_rd(sd_addr);
                    for (int k = 0; k < BL; k++)
                        bus.dram_burst_buf[k*DW +: DW] = sd_burst ? sd_rd(sd_addr + AW'(k)) : 16'($urandom);
                end
            end
        end
    endtask

    task automatic port_step();
        for (int i = 0; i < NP; i++) begin
            if (bus.done[i] && !hold_all[i]) bus.req[i] = 1'b0;
            if (rand_en && !bus.req[i] && $urandom_range(0, 2) == 0) begin
                int kind;
                kind = $urandom_range(0, 2);
                set_port(i, kind == 1, kind == 2,
                         AW'((kind == 2) ? $urandom_range(0, 32) : $urandom_range(0, 63)), 16'($urandom));
            end
        end
        if (rand_en) bus.dram_mem_ready = ($urandom_range(0, 9) != 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.done != 4'h0) begin
            done_log.push_back(bus.done);
            rd_log.push_back(bus.rdata);
            bst_log.push_back(bus.burst_rdata);
        end
        if (bus_p.done != 4'h0) pdone_log.push_back(bus_p.done);
        if (bus.dram_refresh_data) begin
            strobe_cnt++;
            last_saddr = bus.dram_addr; last_sburst = bus.dram_burst_en; last_swe = bus.dram_write_en;
        end
        sdram_step();
        port_step();
        // fixed-latency responder for the fixed-priority instance
        if (bus_p.dram_refresh_data) begin
            p_cnt = 1; bus_p.dram_data_ready = 1'b0;
        end else if (p_cnt == 1) begin
            p_cnt = 0; bus_p.dram_data_ready = 1'b1;
        end else begin
            bus_p.dram_data_ready = 1'b0;
        end
        bus_p.dram_mem_ready = bus.dram_mem_ready;
    endtask

    task automatic wait_dones(input int n, input int budget, input string nm);
        int t;
        t = 0;
        while (done_log.size() < n && t < budget) begin step(); t++; end
        chk(nm, done_log.size() >= n, 1'b1);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while ((bus.busy || bus.req != 4'h0) && t < budget) begin step(); t++; end
        chk("drain_timeout", (bus.busy || bus.req != 4'h0), 1'b0);
    endtask

    initial begin : main
        logic [NP-1:0] rr_exp [5];
        logic [AW-1:0] base;
        logic [DW-1:0] v;
        int t;
        checks = 0; failures = 0;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b0; rand_en = 0; force_delay = 0; sd_cnt = 0; p_cnt = 0; strobe_cnt = 0;
        hold_all = 4'hF;
        bus.req = 4'h0; bus.req_we = 4'h0; bus.req_burst = 4'h0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.dram_mem_ready = 1'b0; bus.dram_data_ready = 1'b0;
        bus.dram_read_data = 16'h0000; bus.dram_burst_buf = '0;
        bus_p.req = 4'hF; bus_p.req_we = 4'h0; bus_p.req_burst = 4'h0; bus_p.req_addr = '0;
        bus_p.req_wdata = '0; bus_p.dram_mem_ready = 1'b0; bus_p.dram_data_ready = 1'b0;
        bus_p.dram_read_data = 16'h0000; bus_p.dram_burst_buf = '0;
        for (int i = 0; i < NP; i++) set_port(i, 1'b0, 1'b0, AW'(i), 16'h0000);

        // reset with all ports requesting, then stall while sdram_ctl initialises
        repeat (3) step();
        chk("t1_done", bus.done, 4'h0);
        chk("t1_strobe", bus.dram_refresh_data, 1'b0);
        chk("t1_busy", bus.busy, 1'b0);
        rst = 1'b1;
        repeat (5) step();
        chk("t1_no_grant_before_ready", strobe_cnt, 0);
        pdone_log.delete();

        // round-robin with req=1111 held back-to-back; fixed-priority twin sees the same
        bus.dram_mem_ready = 1'b1;
        wait_dones(5, 200, "t4_rr_timeout");
        for (int k = 0; k < 5; k++) begin
            if (k < done_log.size()) chk("t4_rr_grant", done_log[k], rr_exp[k]);
        end
        chk("t4_prio_count", pdone_log.size() >= 3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k < pdone_log.size()) chk("t4_prio_grant", pdone_log[k], 4'b0001);
        end
        hold_all = 4'h0;
        drain(300);

        // single read by port 2
        done_log.delete(); rd_log.delete(); strobe_cnt = 0;
        sd_mem[25'd1] = 16'h4809; ref_mem[25'd1] = 16'h4809;
        set_port(2, 1'b0, 1'b0, 25'd1, 16'h0000);
        wait_dones(1, 100, "t2_timeout");
        drain(50);
        chk("t2_strobes", strobe_cnt, 1);
        chk("t2_addr", last_saddr, 25'd1);
        if (done_log.size() > 0) chk("t2_done", done_log[0], 4'b0100);
        if (rd_log.size() > 0) chk("t2_rdata", rd_log[0], 16'h4809);

        // write then read back on port 0
        done_log.delete(); rd_log.delete();
        set_port(0, 1'b1, 1'b0, 25'd0, 16'hABAB);
        wait_dones(1, 100, "t3_wr_timeout");
        drain(50);
        chk("t3_mem", sd_rd(25'd0), 16'hABAB);
        set_port(0, 1'b0, 1'b0, 25'd0, 16'h0000);
        wait_dones(2, 100, "t3_rd_timeout");
        drain(50);
        if (rd_log.size() > 1) chk("t3_rdata", rd_log[1], 16'hABAB);

        // burst read by port 3; req_we set to show it is ignored for bursts
        done_log.delete(); rd_log.delete(); bst_log.delete();
        base = {6'h1, 9'd7, 10'd32};
        for (int k = 0; k < BL; k++) begin
            v = {4'h0, k[3:0], k[3:0], k[3:0]};
            sd_mem[base + AW'(k)] = v; ref_mem[base + AW'(k)] = v;
        end
        set_port(3, 1'b1, 1'b1, base, 16'h5555);
        wait_dones(1, 100, "t5_timeout");
        drain(50);
        chk("t5_burst_en", last_sburst, 1'b1);
        chk("t5_write_en", last_swe, 1'b0);
        if (bst_log.size() > 0) begin
            for (int k = 0; k < BL; k++) begin
                v = {4'h0, k[3:0], k[3:0], k[3:0]};
                chk("t5_word", bst_log[0][k*DW +: DW], v);
            end
        end
        if (rd_log.size() > 0) chk("t5_rdata_word0", rd_log[0], 16'h0000);

        // reset during WAIT of a port-1 read
        done_log.delete(); strobe_cnt = 0; force_delay = 20;
        set_port(1, 1'b0, 1'b0, 25'd5, 16'h0000);
        t = 0;
        while (strobe_cnt == 0 && t < 50) begin step(); t++; end
        step();
        chk("t6_in_wait", bus.busy, 1'b1);
        rst = 1'b0;
        step(); step();
        chk("t6_no_done", done_log.size(), 0);
        chk("t6_busy_clear", bus.busy, 1'b0);
        force_delay = 0;
        set_port(0, 1'b0, 1'b0, 25'd6, 16'h0000);
        set_port(2, 1'b0, 1'b0, 25'd7, 16'h0000);
        rst = 1'b1;
        wait_dones(1, 100, "t6_timeout");
        if (done_log.size() > 0) chk("t6_first_grant", done_log[0], 4'b0001);
        drain(300);

        // random traffic
        rand_en = 1;
        repeat (3000) step();
        rand_en = 0;
        bus.dram_mem_ready = 1'b1;
        drain(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
